// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// the load result-source code and the data-memory wait FSM states.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } mem_state_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding decision for one E-stage ALU operand; the M stage has priority
// over W, and register x0 is never forwarded.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rdm,
    input  logic [4:0] rdw,
    input  logic       regwrite_m,
    input  logic       regwrite_w,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (regwrite_m && (rdm != 5'd0) && (rdm == rs)) begin
            fwd = FWD_MEM;
        end else if (regwrite_w && (rdw != 5'd0) && (rdw == rs)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: operand forwarding, load-use bubbles, branch flushes
// and a memory wait-state freeze. Define HAZARD_PERF_CNT_EN to build the counters.
//
// state | meaning
// IDLE  | no memory access outstanding
// WAIT  | access outstanding, wait_cnt counts the elapsed wait cycles
// ERR   | access timed out; pipe stays frozen until reset
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1d,
    input  logic [4:0]       rs2d,
    input  logic [4:0]       rs1e,
    input  logic [4:0]       rs2e,
    input  logic [4:0]       rde,
    input  logic [4:0]       rdm,
    input  logic [4:0]       rdw,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic [1:0]       resultsrcE,
    input  logic             pcsrcE,
    input  logic             mem_reqM,
    input  logic             mem_ready,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    mem_state_t state;
    logic [7:0] wait_cnt;
    logic       mem_err_q;
    logic       lwstall;
    logic       memstall;

    fwd_sel u_fwd_a (
        .rs         (rs1e),
        .rdm        (rdm),
        .rdw        (rdw),
        .regwrite_m (regwriteM),
        .regwrite_w (regwriteW),
        .fwd        (fwd_a)
    );

    fwd_sel u_fwd_b (
        .rs         (rs2e),
        .rdm        (rdm),
        .rdw        (rdw),
        .regwrite_m (regwriteM),
        .regwrite_w (regwriteW),
        .fwd        (fwd_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_reqM && !mem_ready) begin
                        state    <= WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                WAIT: begin
                    // a late mem_ready still wins over the timeout
                    if (mem_ready) begin
                        state    <= IDLE;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        state     <= ERR;
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ERR:     state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_err  = mem_err_q;
    assign lwstall  = (resultsrcE == RESULTSRC_LOAD) && (rde != 5'd0) &&
                      ((rde == rs1d) || (rde == rs2d));
    assign memstall = ((state == IDLE) && mem_reqM && !mem_ready) ||
                      (state == WAIT) || (state == ERR);

    always_comb begin
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        flushW    = 1'b0;
        forwardAE = fwd_a;
        forwardBE = fwd_b;
        if (reset) begin
            flushD    = 1'b1;
            flushE    = 1'b1;
            flushW    = 1'b1;
            forwardAE = FWD_RF;
            forwardBE = FWD_RF;
        end else if (memstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (pcsrcE) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (lwstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic             any_stall;
    logic             flush_taken;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    assign any_stall   = stallF | stallD | stallE | stallM;
    assign flush_taken = !reset && !memstall && pcsrcE;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (any_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_taken && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cnt;
    assign flush_count  = flush_cnt;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with MEM_TIMEOUT=4; counter checks follow
// whether HAZARD_PERF_CNT_EN is defined for the build.
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic        regwriteM, regwriteW, pcsrcE, mem_reqM, mem_ready;
    logic [1:0]  resultsrcE;
    logic [1:0]  forwardAE, forwardBE;
    logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_err;
    logic [31:0] stall_cycles, flush_count;
    logic [3:0]  stalls;
    logic [2:0]  flushes;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    assign stalls  = {stallF, stallD, stallE, stallM};
    assign flushes = {flushD, flushE, flushW};

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .rs1d(rs1d), .rs2d(rs2d), .rs1e(rs1e), .rs2e(rs2e),
        .rde(rde), .rdm(rdm), .rdw(rdw),
        .regwriteM(regwriteM), .regwriteW(regwriteW),
        .resultsrcE(resultsrcE), .pcsrcE(pcsrcE),
        .mem_reqM(mem_reqM), .mem_ready(mem_ready),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
        regwriteM = 0; regwriteW = 0; resultsrcE = 0; pcsrcE = 0;
        mem_reqM = 0; mem_ready = 0;
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        rs1e = 5; rdm = 5; regwriteM = 1;
        @(negedge clk);
        check("rst_stalls", 32'(stalls), 0);
        check("rst_flushes", 32'(flushes), 32'b111);
        check("rst_fwdA", 32'(forwardAE), 32'(FWD_RF));
        tick();
        reset = 0;
        clear_inputs();
        @(negedge clk);
        check("idle_mem_err", 32'(mem_err), 0);
        check("idle_stalls", 32'(stalls), 0);
        check("idle_flushes", 32'(flushes), 0);

        // forwarding
        rdm = 5; regwriteM = 1; rs1e = 5; rdw = 5; regwriteW = 1; rs2e = 5;
        @(negedge clk);
        check("fwdA_mem_prio", 32'(forwardAE), 32'b10);
        check("fwdB_mem_prio", 32'(forwardBE), 32'b10);
        regwriteM = 0;
        @(negedge clk);
        check("fwdA_wb", 32'(forwardAE), 32'b01);
        rdm = 0; rdw = 0; rs1e = 0; rs2e = 0; regwriteM = 1; regwriteW = 1;
        @(negedge clk);
        check("fwdA_x0", 32'(forwardAE), 32'b00);
        rs2e = 3; rdw = 3;
        @(negedge clk);
        check("fwdB_wb", 32'(forwardBE), 32'b01);
        check("fwdA_still_rf", 32'(forwardAE), 32'b00);
        clear_inputs();

        // load-use
        resultsrcE = 2'b01; rde = 7; rs2d = 7;
        @(negedge clk);
        check("lw_stalls", 32'(stalls), 32'b1100);
        check("lw_flushes", 32'(flushes), 32'b010);
        rde = 0;
        @(negedge clk);
        check("lw_x0_stalls", 32'(stalls), 0);
        check("lw_x0_flushes", 32'(flushes), 0);
        clear_inputs();

        reset = 1;
        tick();
        reset = 0;

        // branch beats load-use
        resultsrcE = 2'b01; rde = 7; rs1d = 7; pcsrcE = 1;
        @(negedge clk);
        check("br_lw_stalls", 32'(stalls), 0);
        check("br_lw_flushes", 32'(flushes), 32'b110);
        tick();
        resultsrcE = 0; rde = 0; rs1d = 0;

        // 3 wait cycles then ready, branch pending in E
        mem_reqM = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("mem_wait%0d_stalls", i), 32'(stalls), 32'b1111);
            check($sformatf("mem_wait%0d_flushes", i), 32'(flushes), 32'b001);
            tick();
        end
        mem_ready = 1;
        @(negedge clk);
        check("mem_ready_stalls", 32'(stalls), 32'b1111);
        check("mem_ready_flushes", 32'(flushes), 32'b001);
        tick();
        mem_reqM = 0; mem_ready = 0;
        @(negedge clk);
        check("post_mem_stalls", 32'(stalls), 0);
        check("post_mem_br_flush", 32'(flushes), 32'b110);
        tick();
        pcsrcE = 0;
        @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
        check("flush_count", flush_count, 2);
        check("stall_cycles", stall_cycles, 4);
`else
        check("flush_count_off", flush_count, 0);
        check("stall_cycles_off", stall_cycles, 0);
`endif

        // zero-wait access
        mem_reqM = 1; mem_ready = 1;
        @(negedge clk);
        check("zero_wait_stalls", 32'(stalls), 0);
        tick();
        mem_reqM = 0; mem_ready = 0;

        // ready arrives exactly on the timeout cycle
        mem_reqM = 1;
        repeat (4) tick();
        mem_ready = 1;
        @(negedge clk);
        check("edge_to_stalls", 32'(stalls), 32'b1111);
        tick();
        mem_reqM = 0; mem_ready = 0;
        @(negedge clk);
        check("edge_to_no_err", 32'(mem_err), 0);
        check("edge_to_released", 32'(stalls), 0);

        // timeout
        mem_reqM = 1;
        repeat (4) tick();
        @(negedge clk);
        check("to_5th_stall", 32'(stalls), 32'b1111);
        check("to_5th_no_err", 32'(mem_err), 0);
        tick();
        mem_reqM = 0;
        @(negedge clk);
        check("err_set", 32'(mem_err), 1);
        check("err_stalls", 32'(stalls), 32'b1111);
        check("err_flushes", 32'(flushes), 32'b001);
        tick();
        @(negedge clk);
        check("err_sticky", 32'(mem_err), 1);
        reset = 1;
        @(negedge clk);
        check("err_rst_stalls", 32'(stalls), 0);
        check("err_rst_flushes", 32'(flushes), 32'b111);
        tick();
        reset = 0;
        @(negedge clk);
        check("err_cleared", 32'(mem_err), 0);
        check("err_cleared_stalls", 32'(stalls), 0);
        check("cnt_cleared", stall_cycles, 0);
        mem_reqM = 1;
        @(negedge clk);
        check("idle_after_rst", 32'(stalls), 32'b1111);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
